// File: rtl/cache_pkg.sv
// Shared types, default geometry and address helpers for the N-way write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_BLOCK_SIZE    = 128;
  localparam int DEF_WAYS          = 4;
  localparam int DEF_SETS          = 4;

  // Derived geometry for the default configuration.
  localparam int WORDS    = DEF_BLOCK_SIZE / DEF_DATA_WIDTH;
  localparam int OFFSET_W = $clog2(WORDS);
  localparam int INDEX_W  = $clog2(DEF_SETS);
  localparam int TAG_W    = DEF_ADDRESS_WIDTH - OFFSET_W - INDEX_W;
  localparam int AGE_W    = $clog2(DEF_WAYS);

  // Extracts a right-aligned bit field from an address of up to 32 bits.
  function automatic logic [31:0] addr_field(input logic [31:0] a,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (a >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracking per set: reports the oldest way and ages the set on access.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(SETS)-1:0]   set_idx,
  input  logic [$clog2(WAYS)-1:0]   access_way,
  input  logic                      update,
  output logic [$clog2(WAYS)-1:0]   victim_way
);

  localparam int AG_W = $clog2(WAYS);

  logic [AG_W-1:0] age_q [SETS][WAYS];
  logic [AG_W-1:0] old_age;

  assign old_age = age_q[set_idx][access_way];

  // The way holding the maximum age in the addressed set is least recently used.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[set_idx][w] == AG_W'(WAYS - 1)) victim_way = AG_W'(w);
    end
  end

  // Accessed way becomes youngest; only ways younger than it age by one, keeping a permutation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AG_W'(w);
    end else if (update) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AG_W'(w) == access_way)
          age_q[set_idx][w] <= '0;
        else if (age_q[set_idx][w] < old_age)
          age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back / write-allocate cache with a block-wide memory port.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   S_IDLE      | waiting for read/write; latches the request
//   S_LOOKUP    | tag compare; hit completes, miss picks a victim
//   S_WRITEBACK | dirty victim line sent to memory until mem_valid
//   S_REFILL    | line fetched from memory until mem_valid, then used
//   S_RESPOND   | one-cycle Done pulse
module nway_wb_cache
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int BLOCK_SIZE    = DEF_BLOCK_SIZE,
  parameter int WAYS          = DEF_WAYS,
  parameter int SETS          = DEF_SETS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic                     read,
  input  logic                     write,
  input  logic [DATA_WIDTH-1:0]    w_data,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    r_data,
  output logic                     cache_req,
  output logic                     cache_write,
  output logic [ADDRESS_WIDTH-1:0] cache_addr,
  output logic [BLOCK_SIZE-1:0]    cache_wdata,
  input  logic                     mem_valid,
  input  logic [BLOCK_SIZE-1:0]    mem_data
);

  localparam int N_WORDS = BLOCK_SIZE / DATA_WIDTH;
  localparam int OFF_W   = $clog2(N_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TG_W    = ADDRESS_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W   = $clog2(WAYS);

  state_t state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     is_write_q;
  logic [WAY_W-1:0]         victim_q;

  logic [BLOCK_SIZE-1:0] data_q  [SETS][WAYS];
  logic [TG_W-1:0]       tag_q   [SETS][WAYS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TG_W-1:0]  tag;

  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, lru_victim, miss_way, lru_way;
  logic             lru_update, fill_done;
  logic [BLOCK_SIZE-1:0] hit_line, fill_line;
  logic [DATA_WIDTH-1:0] hit_word;

  assign off = OFF_W'(addr_field(32'(addr_q), 0, OFF_W));
  assign idx = IDX_W'(addr_field(32'(addr_q), OFF_W, IDX_W));
  assign tag = TG_W'(addr_field(32'(addr_q), OFF_W + IDX_W, TG_W));

  assign fill_done = (state_q == S_REFILL) && mem_valid;
  assign miss_way  = inv_found ? inv_way : lru_victim;

  // Tag match across the set and search for the lowest-index empty way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Hit line with the write word merged, and refill line with an optional merge.
  always_comb begin
    hit_line = data_q[idx][hit_way];
    hit_word = hit_line[off*DATA_WIDTH +: DATA_WIDTH];
    hit_line[off*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
    fill_line = mem_data;
    if (is_write_q) fill_line[off*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
  end

  assign lru_update = ((state_q == S_LOOKUP) && hit) || fill_done;
  assign lru_way    = (state_q == S_LOOKUP) ? hit_way : victim_q;

  cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_idx    (idx),
    .access_way (lru_way),
    .update     (lru_update),
    .victim_way (lru_victim)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (read || write) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)                                                   state_d = S_RESPOND;
        else if (valid_q[idx][miss_way] && dirty_q[idx][miss_way]) state_d = S_WRITEBACK;
        else                                                       state_d = S_REFILL;
      end
      S_WRITEBACK: if (mem_valid) state_d = S_REFILL;
      S_REFILL:    if (mem_valid) state_d = S_RESPOND;
      S_RESPOND:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Memory port and Done are pure functions of the state so they hold steady while stalled.
  always_comb begin
    Done        = 1'b0;
    cache_req   = 1'b0;
    cache_write = 1'b0;
    cache_addr  = '0;
    cache_wdata = '0;
    case (state_q)
      S_WRITEBACK: begin
        cache_req   = 1'b1;
        cache_write = 1'b1;
        cache_addr  = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
        cache_wdata = data_q[idx][victim_q];
      end
      S_REFILL: begin
        cache_req  = 1'b1;
        cache_addr = {tag, idx, {OFF_W{1'b0}}};
      end
      S_RESPOND: Done = 1'b1;
      default: ;
    endcase
  end

  // Request capture in IDLE; read wins when both strobes are high. Victim chosen on a miss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      victim_q   <= '0;
    end else begin
      if ((state_q == S_IDLE) && (read || write)) begin
        addr_q     <= addr;
        wdata_q    <= w_data;
        is_write_q <= write & ~read;
      end
      if ((state_q == S_LOOKUP) && !hit) victim_q <= miss_way;
    end
  end

  // Read data updates only on reads, from the hit line or the arriving refill line.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_data <= '0;
    else if ((state_q == S_LOOKUP) && hit && !is_write_q)
      r_data <= hit_word;
    else if (fill_done && !is_write_q)
      r_data <= mem_data[off*DATA_WIDTH +: DATA_WIDTH];
  end

  // Valid/dirty bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if ((state_q == S_LOOKUP) && hit && is_write_q) begin
      dirty_q[idx][hit_way] <= 1'b1;
    end else if (fill_done) begin
      valid_q[idx][victim_q] <= 1'b1;
      dirty_q[idx][victim_q] <= is_write_q;
    end
  end

  // Line and tag storage; not reset, writes suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if ((state_q == S_LOOKUP) && hit && is_write_q) begin
        data_q[idx][hit_way] <= hit_line;
      end else if (fill_done) begin
        data_q[idx][victim_q] <= fill_line;
        tag_q[idx][victim_q]  <= tag;
      end
    end
  end

endmodule

// File: tb/tb_nway_wb_cache.sv
// Directed bench for nway_wb_cache: word-level reference memory, scoreboard queue for read data,
// and a memory responder with programmable latency that logs every transfer.
module tb_nway_wb_cache;

  logic         clk = 1'b0;
  logic         rst_n, read, write, Done, cache_req, cache_write, mem_valid;
  logic [7:0]   addr, cache_addr;
  logic [31:0]  w_data, r_data;
  logic [127:0] cache_wdata, mem_data;

  always #5 clk = ~clk;

  nway_wb_cache dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .read(read), .write(write), .w_data(w_data),
    .Done(Done), .r_data(r_data), .cache_req(cache_req), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .mem_valid(mem_valid), .mem_data(mem_data)
  );

  int checks = 0;
  int passes = 0;

  logic [31:0] mem_words [256];  // backing memory as seen on the memory port
  logic [31:0] ref_words [256];  // what the CPU should observe
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  int          mem_lat  = 0;
  int          n_refill = 0;
  int          n_wb     = 0;
  int          unstable = 0;
  logic [7:0]  last_rf_addr, last_wb_addr;
  logic [127:0] last_wb_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Memory responder: acks after mem_lat cycles of a held request and checks the request is stable.
  initial begin
    int cnt;
    logic [7:0] a0;
    logic w0;
    cnt = 0;
    a0 = '0;
    w0 = 1'b0;
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      if (!rst_n || !cache_req) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          a0 = cache_addr;
          w0 = cache_write;
        end else if (cache_addr !== a0 || cache_write !== w0) begin
          unstable++;
        end
        if (cnt >= mem_lat) begin
          if (cache_write) begin
            n_wb++;
            last_wb_addr = cache_addr;
            last_wb_data = cache_wdata;
            for (int k = 0; k < 4; k++) mem_words[int'(cache_addr) + k] = cache_wdata[k*32 +: 32];
          end else begin
            n_refill++;
            last_rf_addr = cache_addr;
            for (int k = 0; k < 4; k++) mem_data[k*32 +: 32] = mem_words[int'(cache_addr) + k];
          end
          mem_valid = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // One CPU access; lat = cycles after the sample edge until Done is seen (-1 on timeout).
  task automatic access(input logic [7:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, output int lat);
    logic [31:0] e;
    lat = -1;
    @(negedge clk);
    addr = a; read = rd; write = wr; w_data = wd;
    if (rd) begin
      last_rd = ref_words[a];
    end else begin
      ref_words[a] = wd;
    end
    exp_q.push_back(last_rd);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (Done) begin
        lat = i;
        break;
      end
    end
    e = exp_q.pop_front();
    if (lat < 0) begin
      checks++;
      $error("FAIL done_timeout: addr %0h no Done within 200 cycles", a);
    end else begin
      chk("r_data", r_data, e);
      @(posedge clk); #1;
      chk("done_one_cycle", Done, 1'b0);
    end
  endtask

  initial begin
    int lat, rf0, wb0, done_seen;
    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; w_data = '0;
    last_rd = '0;
    for (int a = 0; a < 256; a++) mem_words[a] = 32'hA5000000 | a;
    mem_words[8'h24] = 32'h11111111;
    mem_words[8'h25] = 32'h22222222;
    mem_words[8'h26] = 32'h33333333;
    mem_words[8'h27] = 32'h44444444;
    ref_words = mem_words;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", Done, 1'b0);
    chk("rst_r_data", r_data, 32'h0);
    chk("rst_cache_req", cache_req, 1'b0);
    chk("rst_cache_write", cache_write, 1'b0);
    chk("rst_cache_addr", cache_addr, 32'h0);
    chk("rst_cache_wdata_lo", cache_wdata[31:0], 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // 1: cold miss then hit
    rf0 = n_refill; wb0 = n_wb;
    access(8'h25, 1'b1, 1'b0, 32'h0, lat);
    chk("s1_refill_count", n_refill - rf0, 1);
    chk("s1_refill_addr", last_rf_addr, 8'h24);
    chk("s1_miss_latency", lat, 2);
    rf0 = n_refill;
    access(8'h25, 1'b1, 1'b0, 32'h0, lat);
    chk("s1_hit_latency", lat, 1);
    chk("s1_hit_no_traffic", n_refill - rf0, 0);

    // 2: write hit, read back
    rf0 = n_refill; wb0 = n_wb;
    access(8'h26, 1'b0, 1'b1, 32'hDEADBEEF, lat);
    chk("s2_write_latency", lat, 1);
    chk("s2_write_no_traffic", (n_refill - rf0) + (n_wb - wb0), 0);
    access(8'h26, 1'b1, 1'b0, 32'h0, lat);

    // 3: fill set 1, then LRU replacement of the clean tag 3 line
    wb0 = n_wb;
    access(8'h24, 1'b1, 1'b0, 32'h0, lat);
    access(8'h34, 1'b1, 1'b0, 32'h0, lat);
    access(8'h44, 1'b1, 1'b0, 32'h0, lat);
    access(8'h54, 1'b1, 1'b0, 32'h0, lat);
    access(8'h24, 1'b1, 1'b0, 32'h0, lat);
    chk("s3_24_hit", lat, 1);
    rf0 = n_refill;
    access(8'h64, 1'b1, 1'b0, 32'h0, lat);
    chk("s3_64_one_refill", n_refill - rf0, 1);
    chk("s3_64_refill_addr", last_rf_addr, 8'h64);
    rf0 = n_refill;
    access(8'h34, 1'b1, 1'b0, 32'h0, lat);
    chk("s3_34_misses", n_refill - rf0, 1);
    access(8'h24, 1'b1, 1'b0, 32'h0, lat);
    chk("s3_24_still_hits", lat, 1);
    chk("s3_no_writeback", n_wb - wb0, 0);

    // 4: dirty tag 3 made LRU, then evicted
    access(8'h35, 1'b0, 1'b1, 32'hCAFEF00D, lat);
    chk("s4_write_hit", lat, 1);
    access(8'h24, 1'b1, 1'b0, 32'h0, lat);
    access(8'h64, 1'b1, 1'b0, 32'h0, lat);
    access(8'h54, 1'b1, 1'b0, 32'h0, lat);
    rf0 = n_refill; wb0 = n_wb;
    access(8'h74, 1'b1, 1'b0, 32'h0, lat);
    chk("s4_wb_count", n_wb - wb0, 1);
    chk("s4_wb_addr", last_wb_addr, 8'h34);
    chk("s4_wb_word1", last_wb_data[63:32], 32'hCAFEF00D);
    chk("s4_refill_after_wb", last_rf_addr, 8'h74);
    chk("s4_wb_latency", lat, 3);
    // evicts tag 2, which still holds DEADBEEF at 0x26
    wb0 = n_wb;
    access(8'h35, 1'b1, 1'b0, 32'h0, lat);
    chk("s4_tag2_wb_addr", last_wb_addr, 8'h24);
    chk("s4_tag2_wb_word2", last_wb_data[95:64], 32'hDEADBEEF);
    chk("s4_tag2_wb_count", n_wb - wb0, 1);

    // 5: stalled memory, then reset in the middle of a refill
    mem_lat = 10; unstable = 0;
    access(8'h09, 1'b1, 1'b0, 32'h0, lat);
    chk("s5_stall_latency", lat, 12);
    chk("s5_req_stable", unstable, 0);
    mem_lat = 1000;
    @(negedge clk);
    addr = 8'h0D; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    @(posedge clk); #1;
    chk("s5_in_refill_req", cache_req, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("s5_rst_req_drop", cache_req, 1'b0);
    chk("s5_rst_no_done", Done, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (Done) done_seen++;
    end
    chk("s5_no_done_after_rst", done_seen, 0);
    ref_words = mem_words;
    last_rd = '0;
    mem_lat = 0;
    rf0 = n_refill;
    access(8'h25, 1'b1, 1'b0, 32'h0, lat);
    chk("s5_25_misses_again", n_refill - rf0, 1);

    // 6: read and write together behave as a read
    wb0 = n_wb;
    access(8'h25, 1'b1, 1'b1, 32'h12345678, lat);
    access(8'h34, 1'b1, 1'b0, 32'h0, lat);
    access(8'h44, 1'b1, 1'b0, 32'h0, lat);
    access(8'h54, 1'b1, 1'b0, 32'h0, lat);
    rf0 = n_refill;
    access(8'h64, 1'b1, 1'b0, 32'h0, lat);
    chk("s6_evict_refill", n_refill - rf0, 1);
    chk("s6_no_writeback", n_wb - wb0, 0);
    access(8'h25, 1'b1, 1'b0, 32'h0, lat);
    access(8'h26, 1'b1, 1'b0, 32'h0, lat);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
